pwm_dac: RTL

PWM_DAC -- requirements
Module: pwm_dac

---
 rtl/pwm_dac.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pwm_dac.sv
// BCD millivolt request -> 12-bit DAC code via digit accumulation and restoring
// division, driving a free-running glitch-free 4096-cycle PWM output.
module pwm_dac #(
    parameter int FS_MV = 1000
) (
    input  logic        DCLK,
    input  logic        RESET,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] code,
    output logic        pwm_out
);

    localparam logic [14:0] FS_W = 15'(FS_MV);

    typedef enum logic [2:0] {IDLE, CHECK, ACCUM, CMP, DIV} state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] digits;
    logic [13:0] acc;
    logic [13:0] rem;
    logic [11:0] quo;
    logic [3:0]  step;
    logic [11:0] cnt;
    logic [11:0] duty;

    logic        digits_ok;
    logic        acc_ge_fs;
    logic [14:0] div_res;
    logic        done_nx;

    function automatic logic all_bcd(input logic [15:0] d);
        return (d[15:12] <= 4'd9) && (d[11:8] <= 4'd9) &&
               (d[7:4]   <= 4'd9) && (d[3:0]  <= 4'd9);
    endfunction

    function automatic logic [13:0] acc_step(input logic [13:0] a, input logic [3:0] dig);
        return a * 14'd10 + {10'd0, dig};
    endfunction

    // Saturation test: anything at or above full scale pins the code at the top.
    function automatic logic at_full_scale(input logic [13:0] a);
        return {1'b0, a} >= FS_W;
    endfunction

    // One restoring-division iteration: {quotient bit, new partial remainder}.
    // The remainder stays below FS_MV, so it always fits in 14 bits.
    function automatic logic [14:0] div_step(input logic [13:0] r);
        logic [14:0] r2;
        r2 = {r, 1'b0};
        if (r2 >= FS_W)
            return {1'b1, 14'(r2 - FS_W)};
        else
            return {1'b0, r2[13:0]};
    endfunction

    assign digits_ok = all_bcd(digits);
    assign acc_ge_fs = at_full_scale(acc);
    assign div_res   = div_step(rem);

    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = CHECK;
            CHECK:   state_nx = digits_ok ? ACCUM : IDLE;
            ACCUM:   if (step == 4'd3) state_nx = CMP;
            CMP:     state_nx = acc_ge_fs ? IDLE : DIV;
            DIV:     if (step == 4'd12) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done_nx = ((state == CHECK) && !digits_ok) ||
                  ((state == CMP) && acc_ge_fs) ||
                  ((state == DIV) && (step == 4'd12));
    end

    // Conversion datapath: DIV spends 12 edges on quotient bits and one to publish.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            done   <= 1'b0;
            err    <= 1'b0;
            code   <= 12'd0;
            digits <= 16'd0;
            acc    <= 14'd0;
            rem    <= 14'd0;
            quo    <= 12'd0;
            step   <= 4'd0;
        end else begin
            done <= done_nx;
            case (state)
                IDLE: begin
                    if (load) begin
                        digits <= data_in;
                        err    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!digits_ok) begin
                        err <= 1'b1;
                    end else begin
                        acc  <= 14'd0;
                        step <= 4'd0;
                    end
                end
                ACCUM: begin
                    acc    <= acc_step(acc, digits[15:12]);
                    digits <= {digits[11:0], 4'd0};
                    step   <= step + 4'd1;
                end
                CMP: begin
                    if (acc_ge_fs) begin
                        code <= 12'hFFF;
                    end else begin
                        rem  <= acc;
                        quo  <= 12'd0;
                        step <= 4'd0;
                    end
                end
                DIV: begin
                    if (step == 4'd12) begin
                        code <= quo;
                    end else begin
                        quo  <= {quo[10:0], div_res[14]};
                        rem  <= div_res[13:0];
                        step <= step + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PWM: duty only changes on the wrap edge, so every period is complete.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= 12'd0;
            duty    <= 12'd0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 12'd1;
            pwm_out <= (cnt < duty);
            if (cnt == 12'hFFF)
                duty <= code;
        end
    end

endmodule
